// File: rtl/ip_bus_pkg.sv
// ip_bus_pkg: shared types and constants for the hard-IP register bus arbiter.
package ip_bus_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  typedef logic grant_t;
  localparam int TIMEOUT_DEF = 255;
  localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;
  localparam logic [7:0] CPU_REGION = 8'h05;
endpackage

// File: rtl/ip_bus_timeout.sv
// ip_bus_timeout: saturating loadable counter with clear, enable and terminal-count flag.
module ip_bus_timeout #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic         ld_i,
  input  logic [W-1:0] ld_val_i,
  input  logic [W-1:0] term_i,
  output logic         tc_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : ld_i ? ld_val_i : (en_i && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign tc_o = cnt_q == term_i;
endmodule

// File: rtl/ip_bus_arbiter.sv
// ip_bus_arbiter: two-master round-robin arbiter onto one valid/ready slave, with
// timeout abort so a dead slave cannot hang the CPU.
module ip_bus_arbiter
  import ip_bus_pkg::*;
#(
  parameter int          ADDR_W   = 24,
  parameter int          TIMEOUT  = TIMEOUT_DEF,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              m0_valid,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wdata,
  input  logic [3:0]        m0_wstrb,
  output logic              m0_ready,
  output logic [31:0]       m0_rdata,
  output logic              m0_err,
  input  logic              m1_valid,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  input  logic [3:0]        m1_wstrb,
  output logic              m1_ready,
  output logic [31:0]       m1_rdata,
  output logic              m1_err,
  output logic              s_valid,
  output logic [ADDR_W-1:0] s_addr,
  output logic [31:0]       s_wdata,
  output logic [3:0]        s_wstrb,
  input  logic              s_ready,
  input  logic [31:0]       s_rdata
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TERM = CW'(TIMEOUT - 1);

  state_t            state_q, state_d;
  grant_t            last_q, last_d, pick;
  logic              any, take, done, tc;
  logic              s_valid_q, s_valid_d;
  logic [ADDR_W-1:0] s_addr_q, s_addr_d;
  logic [31:0]       s_wdata_q, s_wdata_d;
  logic [3:0]        s_wstrb_q, s_wstrb_d;
  logic [1:0]        ready_q, ready_d, err_q, err_d;
  logic [1:0][31:0]  rdata_q, rdata_d;
  logic [31:0]       rsp;

  assign any  = m0_valid | m1_valid;
  assign take = state_q == IDLE && any;
  // On a tie the master that was not granted last wins.
  assign pick = (m0_valid && m1_valid) ? ~last_q : m1_valid;
  assign done = state_q == BUSY && (s_ready || tc);
  assign rsp  = s_ready ? s_rdata : ERR_DATA;

  ip_bus_timeout #(.W(CW)) u_timeout (
    .clk      (clock),
    .rst      (reset),
    .clr_i    (state_q != BUSY),
    .en_i     (state_q == BUSY),
    .ld_i     (1'b0),
    .ld_val_i ('0),
    .term_i   (TERM),
    .tc_o     (tc)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      s_valid_q <= 1'b0;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
      s_wstrb_q <= '0;
      ready_q   <= '0;
      err_q     <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      s_valid_q <= s_valid_d;
      s_addr_q  <= s_addr_d;
      s_wdata_q <= s_wdata_d;
      s_wstrb_q <= s_wstrb_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  always_comb state_d = state_q == IDLE ? (any ? BUSY : IDLE) :
                        state_q == BUSY ? (done ? RESP : BUSY) : IDLE;

  always_comb begin
    last_d     = take ? pick : last_q;
    s_valid_d  = take || (state_q == BUSY && !done);
    s_addr_d   = take ? (pick ? m1_addr : m0_addr) : s_addr_q;
    s_wdata_d  = take ? (pick ? m1_wdata : m0_wdata) : s_wdata_q;
    s_wstrb_d  = take ? (pick ? m1_wstrb : m0_wstrb) : s_wstrb_q;
    ready_d    = {2{done}} & {last_q, ~last_q};
    err_d      = ready_d & {2{~s_ready}};
    rdata_d[0] = ready_d[0] ? rsp : rdata_q[0];
    rdata_d[1] = ready_d[1] ? rsp : rdata_q[1];
  end

  assign s_valid  = s_valid_q;
  assign s_addr   = s_addr_q;
  assign s_wdata  = s_wdata_q;
  assign s_wstrb  = s_wstrb_q;
  assign m0_ready = ready_q[0];
  assign m1_ready = ready_q[1];
  assign m0_err   = err_q[0];
  assign m1_err   = err_q[1];
  assign m0_rdata = rdata_q[0];
  assign m1_rdata = rdata_q[1];
endmodule

// File: tb/tb_ip_bus_arbiter.sv
// tb_ip_bus_arbiter: directed stimulus with a scoreboard of expected slave requests
// and master completions, checked by an independent monitor.
module tb_ip_bus_arbiter;
  typedef struct {
    logic [23:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          blen;
  } req_t;
  typedef struct {
    logic        m;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  logic        clk = 1'b0, rst;
  logic        m0_valid, m0_ready, m0_err, m1_valid, m1_ready, m1_err;
  logic [23:0] m0_addr, m1_addr, s_addr;
  logic [31:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, s_wdata, s_rdata;
  logic [3:0]  m0_wstrb, m1_wstrb, s_wstrb;
  logic        s_valid, s_ready;

  req_t exp_req[$];
  rsp_t exp_rsp[$];
  int   n_cmp = 0, n_bad = 0;
  int   lat = 0, cyc;
  logic [31:0] rd_val = '0;

  ip_bus_arbiter #(.ADDR_W(24), .TIMEOUT(8), .ERR_DATA(32'hDEAD_BEEF)) dut (
    .clock(clk), .reset(rst),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_ready(s_ready), .s_rdata(s_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s", name);
  endtask

  task automatic wait_done(int n, output int c);
    int got = 0;
    c = 0;
    while (got < n && c < 200) begin
      @(negedge clk);
      c++;
      if (m0_ready || m1_ready) got++;
    end
    if (got < n) fail("wait_done timed out");
  endtask

  task automatic push(logic [23:0] a, logic [31:0] wd, logic [3:0] ws, int bl);
    req_t r;
    r.addr = a; r.wdata = wd; r.wstrb = ws; r.blen = bl;
    exp_req.push_back(r);
  endtask

  task automatic push_rsp(logic m, logic [31:0] rd, logic e);
    rsp_t r;
    r.m = m; r.rdata = rd; r.err = e;
    exp_rsp.push_back(r);
  endtask

  // Slave model: ready on BUSY cycle lat (0-based) of each burst; lat<0 never responds.
  initial begin
    int busy = 0;
    s_ready = 1'b0;
    forever begin
      @(negedge clk);
      busy = s_valid ? busy + 1 : 0;
      s_ready = lat >= 0 && busy == lat + 1;
      s_rdata = rd_val;
    end
  end

  initial begin
    logic prev_sv = 1'b0, prev_r0 = 1'b0, prev_r1 = 1'b0, unstable = 1'b0;
    int   blen = 0;
    req_t cur, r;
    rsp_t e;
    cur = '{addr: '0, wdata: '0, wstrb: '0, blen: -1};
    forever begin
      @(negedge clk);
      if (s_valid === 1'b1 && !prev_sv) begin
        if (exp_req.size() == 0) fail("unexpected s_valid burst");
        else begin
          r = exp_req.pop_front();
          check("s_addr", s_addr, r.addr);
          check("s_wdata", s_wdata, r.wdata);
          check("s_wstrb", s_wstrb, r.wstrb);
          cur = r;
        end
        blen = 1;
        unstable = 1'b0;
      end else if (s_valid === 1'b1) begin
        blen++;
        if ({s_addr, s_wdata, s_wstrb} !== {cur.addr, cur.wdata, cur.wstrb}) unstable = 1'b1;
      end else if (prev_sv) begin
        if (cur.blen >= 0) check("burst_len", blen, cur.blen);
        check("s_stable", unstable, 0);
      end
      if (m0_ready === 1'b1 || m1_ready === 1'b1) begin
        check("both_ready", m0_ready & m1_ready, 0);
        check("ready_pulse", (m0_ready & prev_r0) | (m1_ready & prev_r1), 0);
        if (exp_rsp.size() == 0) fail("unexpected completion");
        else begin
          e = exp_rsp.pop_front();
          check("grant", m1_ready, e.m);
          check("rdata", m1_ready ? m1_rdata : m0_rdata, e.rdata);
          check("err", m1_ready ? m1_err : m0_err, e.err);
        end
      end
      if (!rst && ((m0_err & ~m0_ready) | (m1_err & ~m1_ready)) === 1'b1) fail("err without ready");
      prev_sv = s_valid === 1'b1;
      prev_r0 = m0_ready === 1'b1;
      prev_r1 = m1_ready === 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    {m0_valid, m1_valid} = '0;
    {m0_addr, m0_wdata, m0_wstrb, m1_addr, m1_wdata, m1_wstrb} = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst s_valid", s_valid, 0);
    check("rst s_addr", {s_addr, s_wdata, s_wstrb}, 0);
    check("rst ready", {m0_ready, m1_ready}, 0);
    check("rst err", {m0_err, m1_err}, 0);
    check("rst rdata", {m0_rdata, m1_rdata}, 0);
    rst = 1'b0;
    // m0 write, slave ready on third BUSY cycle
    rd_val = 32'h0BAD_0001; lat = 2;
    m0_valid = 1; m0_addr = 24'h10; m0_wdata = 32'hA5; m0_wstrb = 4'hF;
    push(24'h10, 32'hA5, 4'hF, 3); push_rsp(0, 32'h0BAD_0001, 0);
    wait_done(1, cyc);
    m0_valid = 0;
    repeat (2) @(negedge clk);
    // m1 read, slave ready on first BUSY cycle
    rd_val = 32'h1234_5678; lat = 0;
    m1_valid = 1; m1_addr = 24'h20; m1_wdata = 0; m1_wstrb = 0;
    push(24'h20, 0, 0, 1); push_rsp(1, 32'h1234_5678, 0);
    wait_done(1, cyc);
    m1_valid = 0;
    check("m1 latency", cyc, 2);
    check("m0_rdata hold", m0_rdata, 32'h0BAD_0001);
    // both continuously valid after reset: 0,1,0,1
    rst = 1; repeat (2) @(negedge clk); rst = 0;
    rd_val = 32'hCAFE_0000;
    m0_valid = 1; m0_addr = 24'h100; m0_wdata = 1; m0_wstrb = 1;
    m1_valid = 1; m1_addr = 24'h200; m1_wdata = 2; m1_wstrb = 2;
    for (int i = 0; i < 2; i++) begin
      push(24'h100, 1, 1, 1); push_rsp(0, 32'hCAFE_0000, 0);
      push(24'h200, 2, 2, 1); push_rsp(1, 32'hCAFE_0000, 0);
    end
    wait_done(4, cyc);
    {m0_valid, m1_valid} = '0;
    repeat (2) @(negedge clk);
    // dead slave: abort after 8 cycles, then a normal transaction
    lat = -1;
    m0_valid = 1; m0_addr = 24'h40; m0_wdata = 0; m0_wstrb = 0;
    push(24'h40, 0, 0, 8); push_rsp(0, 32'hDEAD_BEEF, 1);
    wait_done(1, cyc);
    m0_valid = 0;
    repeat (2) @(negedge clk);
    lat = 1; rd_val = 32'h55AA_55AA;
    m0_valid = 1; m0_addr = 24'h44; m0_wdata = 32'h77; m0_wstrb = 4'h3;
    push(24'h44, 32'h77, 4'h3, 2); push_rsp(0, 32'h55AA_55AA, 0);
    wait_done(1, cyc);
    m0_valid = 0;
    repeat (2) @(negedge clk);
    // reset during the third BUSY cycle abandons the transaction
    lat = -1;
    m0_valid = 1; m0_addr = 24'h60; m0_wdata = 0; m0_wstrb = 0;
    push(24'h60, 0, 0, -1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1; m0_valid = 0;
    @(negedge clk);
    check("mid-rst s_valid", s_valid, 0);
    check("mid-rst ready", {m0_ready, m1_ready}, 0);
    rst = 0; lat = 0; rd_val = 32'h1357_2468;
    m0_valid = 1; m0_addr = 24'h300; m0_wdata = 3; m0_wstrb = 4'h1;
    m1_valid = 1; m1_addr = 24'h400; m1_wdata = 4; m1_wstrb = 4'h2;
    push(24'h300, 3, 4'h1, 1); push_rsp(0, 32'h1357_2468, 0);
    wait_done(1, cyc);
    {m0_valid, m1_valid} = '0;
    repeat (2) @(negedge clk);
    // master drops valid and changes address while BUSY
    lat = 3; rd_val = 32'h600D_F00D;
    m0_valid = 1; m0_addr = 24'h500; m0_wdata = 9; m0_wstrb = 4'hF;
    push(24'h500, 9, 4'hF, 4); push_rsp(0, 32'h600D_F00D, 0);
    @(negedge clk);
    m0_valid = 0; m0_addr = 24'h777;
    wait_done(1, cyc);
    repeat (3) @(negedge clk);
    check("req queue empty", exp_req.size(), 0);
    check("rsp queue empty", exp_rsp.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
